// File: rtl/game_flow_if.sv
// Handshake bundle between the game flow controller and the sprite datapath.
// The controller takes the slave view; the datapath (or a bench) takes the master view.
interface game_flow_if;
   logic       start_btn;
   logic       pacman_is_dead;
   logic       level_clear;
   logic       move_en;
   logic       sprite_rst;
   logic       food_reload;
   logic [1:0] lives;
   logic [3:0] level;
   logic [2:0] state;
   logic       game_over;

   modport master (
      output start_btn, pacman_is_dead, level_clear,
      input  move_en, sprite_rst, food_reload, lives, level, state, game_over
   );

   modport slave (
      input  start_btn, pacman_is_dead, level_clear,
      output move_en, sprite_rst, food_reload, lives, level, state, game_over
   );
endinterface

// File: rtl/game_flow_controller.sv
// Round/lives sequencer: owns the game state machine, paces sprite movement with
// a periodic tick, and emits sprite/food reload pulses plus lives/level counters.
module game_flow_controller #(
   parameter int TICK_DIV    = 4,
   parameter int READY_TICKS = 2,
   parameter int DYING_TICKS = 3,
   parameter int START_LIVES = 3,
   parameter int MAX_LEVEL   = 15
) (
   input  logic        clk,
   input  logic        rst,
   game_flow_if.slave  gf
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_READY     = 3'd1,
      S_PLAY      = 3'd2,
      S_DYING     = 3'd3,
      S_LEVEL_UP  = 3'd4,
      S_GAME_OVER = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [7:0]    wait_q, wait_d;
   logic          start_q;
   logic [1:0]    lives_q, lives_d;
   logic [3:0]    level_q, level_d;
   logic          move_en_q, move_en_d;
   logic          sprite_rst_q, sprite_rst_d;
   logic          food_reload_q, food_reload_d;
   logic          game_over_q, game_over_d;
   logic          tick;
   logic          start_rise;

   function automatic logic [3:0] level_sat_inc(input logic [3:0] l);
      return (l >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : l + 4'd1;
   endfunction

   assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign start_rise = gf.start_btn & ~start_q;
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

   always_comb begin
      state_d       = state_q;
      lives_d       = lives_q;
      level_d       = level_q;
      move_en_d     = 1'b0;
      sprite_rst_d  = 1'b0;
      food_reload_d = 1'b0;
      case (state_q)
         S_IDLE, S_GAME_OVER: begin
            if (start_rise) begin
               state_d       = S_READY;
               lives_d       = 2'(START_LIVES);
               level_d       = '0;
               sprite_rst_d  = 1'b1;
               food_reload_d = 1'b1;
            end
         end
         S_READY: begin
            if (tick && wait_q == 8'(READY_TICKS - 1))
               state_d = S_PLAY;
         end
         S_PLAY: begin
            // Death wins over a simultaneous level clear.
            if (gf.pacman_is_dead) begin
               state_d = S_DYING;
               lives_d = lives_q - 2'd1;
            end else if (gf.level_clear) begin
               state_d = S_LEVEL_UP;
            end else begin
               move_en_d = tick;
            end
         end
         S_DYING: begin
            if (tick && wait_q == 8'(DYING_TICKS - 1)) begin
               if (lives_q == 2'd0) begin
                  state_d = S_GAME_OVER;
               end else begin
                  state_d      = S_READY;
                  sprite_rst_d = 1'b1;
               end
            end
         end
         S_LEVEL_UP: begin
            state_d       = S_READY;
            sprite_rst_d  = 1'b1;
            food_reload_d = 1'b1;
            level_d       = level_sat_inc(level_q);
         end
         default: state_d = S_IDLE;
      endcase

      game_over_d = (state_d == S_GAME_OVER);

      // Wait counter measures ticks spent in the current READY/DYING visit.
      if (state_d != state_q)
         wait_d = '0;
      else if (tick && (state_q == S_READY || state_q == S_DYING))
         wait_d = wait_q + 8'd1;
      else
         wait_d = wait_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         tick_cnt_q    <= '0;
         wait_q        <= '0;
         start_q       <= 1'b0;
         lives_q       <= 2'(START_LIVES);
         level_q       <= '0;
         move_en_q     <= 1'b0;
         sprite_rst_q  <= 1'b0;
         food_reload_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         wait_q        <= wait_d;
         start_q       <= gf.start_btn;
         lives_q       <= lives_d;
         level_q       <= level_d;
         move_en_q     <= move_en_d;
         sprite_rst_q  <= sprite_rst_d;
         food_reload_q <= food_reload_d;
         game_over_q   <= game_over_d;
      end
   end

   assign gf.state       = state_q;
   assign gf.lives       = lives_q;
   assign gf.level       = level_q;
   assign gf.move_en     = move_en_q;
   assign gf.sprite_rst  = sprite_rst_q;
   assign gf.food_reload = food_reload_q;
   assign gf.game_over   = game_over_q;
endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Round/lives sequencer sitting above the sprite game-logic datapath. It owns the game state machine (idle, ready, play, dying, level-up, game-over) and generates the periodic movement-enable tick that paces all sprite position updates. It also generates sprite/food reload pulses and maintains lives and level counters. It consumes the aggregated pacman death flag and a level-clear flag from the food tracker, and drives the datapath's sprite reset and move gating.

## Interface
Parameters:
- TICK_DIV, 4, clock cycles per movement tick (≥2)
- READY_TICKS, 2, movement ticks spent in READY before play (1–255)
- DYING_TICKS, 3, movement ticks spent in DYING (1–255)
- START_LIVES, 3, lives loaded on new game (1–3)
- MAX_LEVEL, 15, level counter saturation value (≤15)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- start_btn  in  1  start button, synchronous level; acted on rising edge only
- pacman_is_dead  in  1  OR of all ghost collisions, level
- level_clear  in  1  all food eaten, level
- move_en  out  1  one-cycle pulse per movement tick while playing
- sprite_rst  out  1  one-cycle pulse: reload all sprite reset positions
- food_reload  out  1  one-cycle pulse: restore all food
- lives  out  2  remaining lives
- level  out  4  current level, 0-based
- state  out  3  current state encoding
- game_over  out  1  high while in GAME_OVER

## Operation
- States and encodings: IDLE=0, READY=1, PLAY=2, DYING=3, LEVEL_UP=4, GAME_OVER=5; 6,7 unreachable and treated as IDLE on the next clock.
- Tick counter: free-running 0..TICK_DIV-1 in every state, wrapping to 0. Cycle with count==TICK_DIV-1 is a tick cycle.
- Wait counter (8 bit): cleared on every state change, incremented on each tick cycle in READY and DYING.
- start_rise = start_btn & ~start_q, where start_q is a registered copy of start_btn.
- IDLE:
  - On start_rise, load lives=START_LIVES and level=0.
  - Pulse sprite_rst and food_reload, then go to READY.
- READY:
  - When a tick cycle occurs with wait==READY_TICKS-1, go to PLAY.
  - move_en stays low.
- PLAY:
  - move_en pulses once per tick.
  - pacman_is_dead=1: lives decrements, go to DYING.
  - Otherwise, level_clear=1: go to LEVEL_UP.
  - Death has priority over level_clear in the same cycle.
- DYING:
  - When a tick cycle occurs with wait==DYING_TICKS-1:
    - lives==0: go to GAME_OVER.
    - Otherwise: pulse sprite_rst, go to READY (food untouched).
- LEVEL_UP (one cycle): pulse sprite_rst and food_reload, level=min(level+1,MAX_LEVEL), go to READY.
- GAME_OVER:
  - game_over=1.
  - On start_rise, behave as IDLE start: reload lives and level, pulse sprite_rst and food_reload, go to READY.
- Ignored inputs:
  - pacman_is_dead and level_clear are ignored outside PLAY.
  - start_btn is ignored outside IDLE and GAME_OVER.
- lives never wraps below 0: a decrement only occurs from PLAY, and lives≥1 in PLAY.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, lives=START_LIVES, level=0, move_en=0, sprite_rst=0, food_reload=0, game_over=0. Tick counter, wait counter and start_q are 0.
- Asynchronous reset mid-operation forces all reset values immediately, including any pulse in flight.
- Transitions take effect one clock after the qualifying input is sampled.
  - sprite_rst and food_reload are high for exactly the cycle in which the new state first appears on `state`.
- move_en is high in the cycle after a tick cycle only if state was PLAY during that tick cycle and no exit condition was sampled in it.
- The lives and level updates appear in the same cycle as the new state.
- Reaching PLAY takes READY_TICKS ticks after entering READY, i.e. at most READY_TICKS*TICK_DIV cycles after entry.

## Test plan
- Reset then hold start_btn=1 for 10 cycles:
  - Exactly one sprite_rst and one food_reload pulse; lives=3, level=0, state=1.
  - state=2 within 8 cycles.
- In PLAY with pacman_is_dead=0 and level_clear=0 for 40 cycles (TICK_DIV=4): exactly 10 move_en pulses, spaced 4 cycles apart.
- In PLAY, assert pacman_is_dead and level_clear together:
  - Next cycle state=3 and lives=2; no food_reload.
  - After 3 ticks, sprite_rst pulses and state=1.
- Three successive deaths from START_LIVES=3:
  - lives reaches 0, state=5, game_over=1.
  - Further deaths ignored; start rise returns lives=3, level=0, state=1.
- Assert level_clear 16 times across rounds: level steps 1..15 then stays at 15; each step gives one food_reload pulse.
- Assert rst for 1 cycle while in DYING with sprite_rst pending: all outputs are immediately at reset values and state=0.
